// File: rtl/had_div_seq.sv
// rtl/had_div_seq.sv - sequential 4-lane x 4-bit restoring Hadamard divider (optional HAD_DIV_REM_EN exposes remainders on port r)
module had_div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] z,
    output logic [3:0]  dz
`ifdef HAD_DIV_REM_EN
    ,
    output logic [15:0] r
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Operands and per-lane working state. Nibble k of each word holds the
    // lane whose flag sits at dz[k], so the same slicing serves all words.
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [3:0]  r_dz_lat;
    logic [15:0] r_q;
    logic [15:0] r_rem;
    logic [1:0]  r_cnt;

    // Registered results; only written on the final CALC step.
    logic [15:0] r_z;
    logic [3:0]  r_dz;
`ifdef HAD_DIV_REM_EN
    logic [15:0] r_r;
`endif

    logic        w_accept;
    logic        w_last;
    logic [15:0] w_q_next;
    logic [15:0] w_rem_next;
    logic [3:0]  w_dz_in;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_state == S_CALC) && (r_cnt == 2'd0);

    // Divide-by-zero flags of the incoming divisors, one per nibble.
    always_comb begin
        w_dz_in = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_dz_in[k] = (y[4*k +: 4] == 4'h0);
        end
    end

    // One restoring-division step for every lane: bring down the next
    // dividend bit (MSB first), trial-subtract, and shift the quotient bit in.
    // A zero divisor always "fits", which yields q=F and rem=dividend for free.
    always_comb begin
        logic [3:0] v_nib;
        logic [4:0] v_p;
        logic [4:0] v_d;
        logic       v_qbit;
        w_q_next   = r_q;
        w_rem_next = r_rem;
        v_nib      = 4'h0;
        v_p        = 5'h00;
        v_d        = 5'h00;
        v_qbit     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v_nib  = r_x[4*k +: 4];
            v_p    = {r_rem[4*k +: 4], v_nib[r_cnt]};
            v_d    = {1'b0, r_y[4*k +: 4]};
            v_qbit = (v_p >= v_d);
            if (v_qbit) begin
                v_p = v_p - v_d;
            end
            // The remainder before the last step never exceeds the top three
            // dividend bits, so the 5-bit trial value always fits back in 4.
            w_rem_next[4*k +: 4] = v_p[3:0];
            w_q_next[4*k +: 4]   = {r_q[4*k +: 3], v_qbit};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; no bypass from DONE straight into a new accept.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == 2'd0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM outputs: handshake flags decoded from the current state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Working registers: load on accept, step once per CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= 16'h0000;
            r_y      <= 16'h0000;
            r_dz_lat <= 4'b0000;
            r_q      <= 16'h0000;
            r_rem    <= 16'h0000;
            r_cnt    <= 2'd0;
        end else if (w_accept) begin
            r_x      <= x;
            r_y      <= y;
            r_dz_lat <= w_dz_in;
            r_q      <= 16'h0000;
            r_rem    <= 16'h0000;
            r_cnt    <= 2'd3;
        end else if (r_state == S_CALC) begin
            r_q      <= w_q_next;
            r_rem    <= w_rem_next;
            r_cnt    <= r_cnt - 2'd1;
        end
    end

    // Result registers: updated only on the transition into DONE so the
    // outputs never expose partial quotients and hold between operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z  <= 16'h0000;
            r_dz <= 4'b0000;
`ifdef HAD_DIV_REM_EN
            r_r  <= 16'h0000;
`endif
        end else if (w_last) begin
            r_z  <= w_q_next;
            r_dz <= r_dz_lat;
`ifdef HAD_DIV_REM_EN
            r_r  <= w_rem_next;
`endif
        end
    end

    assign z  = r_z;
    assign dz = r_dz;
`ifdef HAD_DIV_REM_EN
    assign r  = r_r;
`endif

endmodule

// File: tb/tb_had_div_seq.sv
// tb/tb_had_div_seq.sv - self-checking bench for had_div_seq
module tb_had_div_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic [3:0]  dz;
`ifdef HAD_DIV_REM_EN
    logic [15:0] r;
`endif

    int total;
    int bad;

    had_div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .dz        (dz)
`ifdef HAD_DIV_REM_EN
        ,
        .r         (r)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division per lane; divisor 0 gives q=15, rem=dividend.
    task automatic model(input logic [15:0] xv, input logic [15:0] yv,
                         output logic [15:0] ez, output logic [3:0] edz, output logic [15:0] er);
        int a;
        int b;
        ez  = 16'h0;
        edz = 4'h0;
        er  = 16'h0;
        for (int lane = 0; lane < 4; lane++) begin
            a = int'(xv[15-4*lane -: 4]);
            b = int'(yv[15-4*lane -: 4]);
            if (b == 0) begin
                ez[15-4*lane -: 4] = 4'hF;
                er[15-4*lane -: 4] = 4'(a);
                edz[3-lane]        = 1'b1;
            end else begin
                ez[15-4*lane -: 4] = 4'(a / b);
                er[15-4*lane -: 4] = 4'(a % b);
            end
        end
    endtask

    task automatic chk_result(input string tag, input logic [15:0] ez, input logic [3:0] edz,
                              input logic [15:0] er);
        chk({tag, "_z"}, 32'(z), 32'(ez));
        chk({tag, "_dz"}, 32'(dz), 32'(edz));
`ifdef HAD_DIV_REM_EN
        chk({tag, "_r"}, 32'(r), 32'(er));
`endif
    endtask

    // Full transaction: accept, measure latency, check result, optionally stall, release.
    task automatic do_op(input string tag, input logic [15:0] xv, input logic [15:0] yv, input int stall);
        int n;
        logic [15:0] ez;
        logic [15:0] er;
        logic [3:0]  edz;
        model(xv, yv, ez, edz, er);
        x = xv;
        y = yv;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        x = 16'($urandom);
        y = 16'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk_result(tag, ez, edz, er);
        for (int k = 0; k < stall; k++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_z"}, 32'(z), 32'(ez));
        end
        out_ready = 1'b1;
        tick();
        chk({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_keep_z"}, 32'(z), 32'(ez));
    endtask

    initial begin
        logic [15:0] ez;
        logic [15:0] er;
        logic [3:0]  edz;
        logic [15:0] xr;
        logic [15:0] yr;
        int n;
        int cyc;
        int acc_cyc[$];
        logic [15:0] res[$];

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = 16'h0;
        y         = 16'h0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk_result("rst", 16'h0000, 4'b0000, 16'h0000);

        // Directed operations from the plan, checked against fixed expected values.
        do_op("t1", 16'h9F64, 16'h3521, 0);
        chk_result("t1_const", 16'h3334, 4'b0000, 16'h0000);
        do_op("t2", 16'hFEDC, 16'h4321, 0);
        chk_result("t2_const", 16'h346C, 4'b0000, 16'h3210);
        do_op("t3", 16'h7800, 16'h0230, 0);
        chk_result("t3_const", 16'hF40F, 4'b1001, 16'h7000);

        // Backpressure: a stalled result must stay put and ignore new operands.
        model(16'hC5A3, 16'h2301, ez, edz, er);
        x = 16'hC5A3;
        y = 16'h2301;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_latency", 32'(n), 32'd4);
        x = 16'h1234;
        y = 16'h1111;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk_result("bp_hold", ez, edz, er);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
        chk("bp_rel_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("bp_no_ghost", 32'(out_valid), 32'd0);
        end
        chk_result("bp_after", ez, edz, er);

        // Reset during the second CALC cycle discards the operation.
        x = 16'hFFFF;
        y = 16'h1234;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk_result("mid_rst", 16'h0000, 4'b0000, 16'h0000);
        do_op("post_rst", 16'h1111, 16'h1111, 0);
        chk_result("post_rst_const", 16'h1111, 4'b0000, 16'h0000);

        // Back-to-back with in_valid held high: accepts 6 cycles apart.
        x = 16'h8642;
        y = 16'h2222;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        while (res.size() < 2 && cyc < 40) begin
            if (out_valid) res.push_back(z);
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                tick();
                if (acc_cyc.size() == 1) begin
                    x = 16'hFFFF;
                    y = 16'hFFFF;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                tick();
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("b2b_results", 32'(res.size()), 32'd2);
        chk("b2b_accepts", 32'(acc_cyc.size()), 32'd2);
        if (res.size() == 2 && acc_cyc.size() == 2) begin
            chk("b2b_zA", 32'(res[0]), 32'h4321);
            chk("b2b_zB", 32'(res[1]), 32'h1111);
            chk("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
        end
        tick();

        // Randomized operations with random stalls, including zero divisors.
        for (int t = 0; t < 24; t++) begin
            xr = 16'($urandom);
            yr = 16'($urandom);
            if (t % 4 == 0) yr[4*(t % 16 / 4) +: 4] = 4'h0;
            do_op("rand", xr, yr, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/had_div_seq.md
# had_div_seq

Sequential lane-wise (Hadamard) divider for packed 4-lane, 4-bit unsigned vectors. It is the inverse counterpart of the combinational Hadamard multiplier: it recovers the per-lane quotient of two packed operand words. It is used in the normalisation and scaling stages of the NN datapath. All four lanes use restoring division in parallel, one quotient bit per cycle, behind valid/ready handshakes on both the input and output sides.

## Interface
- No parameters. Lane count is fixed at 4 and lane width at 4 bits.
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- x  input  16  packed dividends; lane0 = x[15:12], lane1 = x[11:8], lane2 = x[7:4], lane3 = x[3:0].
- y  input  16  packed divisors, same packing.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- z  output  16  packed quotients, same packing.
- dz  output  4  divide-by-zero flags; dz[3-i] = lane i divisor was 0.
- r  output  16  packed remainders, same packing. Present only with HAD_DIV_REM_EN.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid, the block latches x, y and dz, clears the quotient and partial-remainder registers, loads the bit counter with 3, and goes to CALC.
- CALC: in_ready=0, out_valid=0. Each cycle, per lane:
  - p = {rem[2:0], dividend[cnt]} (5-bit compare).
  - If p >= divisor: rem = p - divisor and q[cnt] = 1.
  - Otherwise: rem = p and q[cnt] = 0.
  - When cnt==0, go to DONE. Otherwise decrement cnt.
- DONE: out_valid=1 and z/dz/r are stable. On out_ready, go to IDLE. While out_ready=0, hold all outputs unchanged indefinitely.
- Divide by zero is not special-cased in the datapath. Restoring division naturally yields q=4'hF and r=dividend. dz flags the lane.
- All arithmetic is unsigned. The quotient always fits in 4 bits. The remainder is always less than the divisor, except in the divide-by-zero case.
- Inputs are ignored outside IDLE. in_valid held high during CALC/DONE has no effect.
- There is no bypass. The block does not accept new operands in the same cycle DONE is released. The next accept is possible one cycle after the out_ready handshake.

## Timing
- Reset values: in_ready=1, out_valid=0, z=16'h0000, dz=4'b0000, r=16'h0000. The FSM is in IDLE.
- Accept at rising edge E0 (in_valid & in_ready).
- CALC occupies edges E1..E4. out_valid is first high after E4, giving a latency of 4 cycles from accept.
- With out_ready tied high, the result is consumed at E5 and in_ready is high after E5. Maximum throughput is one operation per 6 cycles.
- z/dz/r update only on the E4 transition into DONE. Between operations they retain the last result and never show intermediate quotient bits.
- rst asserted in any state, including mid-CALC or DONE with out_valid high, takes effect at the next edge. The in-flight result is discarded and all outputs return to their reset values. rst has priority over every handshake.

## Configuration
- HAD_DIV_REM_EN:
  - Defined: port r exists and carries the final per-lane remainders.
  - Undefined: port r is absent. Remainders are still computed internally, because the restoring algorithm needs them, but they are not registered to an output. Quotient and dz behaviour is identical in both builds.

## Test plan
- Reset, then x=16'h9F64, y=16'h3521, out_ready=1 → out_valid rises 4 cycles after accept; z=16'h3334, dz=4'b0000, r=16'h0000.
- x=16'hFEDC, y=16'h4321 → z=16'h346C, r=16'h3210 (HAD_DIV_REM_EN build); in the non-REM build, z identical and no r port.
- x=16'h7800, y=16'h0230 → z=16'hF40F, dz=4'b1001, r=16'h7000.
- Backpressure: out_ready=0 for 10 cycles after out_valid → z/dz/r/out_valid constant, in_ready=0, and a new in_valid is ignored. Raising out_ready → IDLE next cycle, and the ignored operands are not processed.
- rst pulsed for one cycle on the second CALC cycle → next cycle in_ready=1, out_valid=0, z=0, dz=0. A fresh x=16'h1111, y=16'h1111 then gives z=16'h1111.
- Back-to-back: in_valid held high with operand sets A=(16'h8642, 16'h2222) and B=(16'hFFFF, 16'hFFFF), out_ready=1 → results 16'h4321 and then 16'h1111, with accepts exactly 6 cycles apart.
